// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, counter sizing.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
// Configuration: MDU_MADD_EN (enables accumulate ops 6..9) is consumed by mdu_ctrl.
package mdu_pkg;

   // Default latencies; mdu_ctrl takes these as parameter defaults.
   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // Op code encoding as driven by the decoder.
   localparam logic [3:0] MD_MULT  = 4'd0;
   localparam logic [3:0] MD_MULTU = 4'd1;
   localparam logic [3:0] MD_DIV   = 4'd2;
   localparam logic [3:0] MD_DIVU  = 4'd3;
   localparam logic [3:0] MD_MTHI  = 4'd4;
   localparam logic [3:0] MD_MTLO  = 4'd5;
   localparam logic [3:0] MD_MADD  = 4'd6;
   localparam logic [3:0] MD_MADDU = 4'd7;
   localparam logic [3:0] MD_MSUB  = 4'd8;
   localparam logic [3:0] MD_MSUBU = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } md_state_e;

   // The counter is loaded with N-1 and counts down to 0, so it only has to
   // represent values up to max(N)-1.
   function automatic int cnt_width(input int mult_cycles, input int div_cycles);
      int mx;
      mx = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
      return (mx <= 2) ? 1 : $clog2(mx);
   endfunction

   localparam int CNT_W = cnt_width(MULT_CYCLES_DEF, DIV_CYCLES_DEF);

   function automatic logic is_mul_op(input logic [3:0] op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_acc_op(input logic [3:0] op);
      return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: 64-bit product, quotient, remainder and divide-by-zero flag.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; results are valid whenever the inputs are.
// Ports: a_i/b_i operands, op_i selects signedness; prod_o, quot_o, rem_o, div0_o results.
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [3:0]  op_i,
   output logic [63:0] prod_o,
   output logic [31:0] quot_o,
   output logic [31:0] rem_o,
   output logic        div0_o
);

   logic        sgn;
   logic [63:0] a_ext;
   logic [63:0] b_ext;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] dvs;
   logic [31:0] q_mag;
   logic [31:0] r_mag;

   always_comb begin
      sgn = (op_i == MD_MULT) || (op_i == MD_DIV) ||
            (op_i == MD_MADD) || (op_i == MD_MSUB);

      // Low 64 bits of the product of the 64-bit extensions equal the
      // signed or unsigned 32x32 product depending on the extension.
      a_ext  = {{32{sgn & a_i[31]}}, a_i};
      b_ext  = {{32{sgn & b_i[31]}}, b_i};
      prod_o = a_ext * b_ext;

      // Signed division on magnitudes, then fix signs: quotient truncates
      // toward zero, remainder follows the dividend. 0x80000000 / -1 falls
      // out naturally: magnitude 0x80000000 negates back to itself.
      a_neg  = sgn & a_i[31];
      b_neg  = sgn & b_i[31];
      a_mag  = a_neg ? (32'd0 - a_i) : a_i;
      b_mag  = b_neg ? (32'd0 - b_i) : b_i;
      div0_o = (b_i == 32'd0);
      dvs    = div0_o ? 32'd1 : b_mag;   // keeps the divider X-free; result is discarded
      q_mag  = a_mag / dvs;
      r_mag  = a_mag % dvs;
      quot_o = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      rem_o  = a_neg ? (32'd0 - r_mag) : r_mag;
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; issues pipeline stall for MD ops and mf*.
// Latency: op accepted at edge E holds busy for MULT_CYCLES/DIV_CYCLES and commits HI/LO at E+N.
// Backpressure: start while busy is ignored; stall = md_req & (busy | start) holds the issuer.
// Ports: clk, rst_n (async low), start/op/a/b/md_req from decoder; busy, stall, hi, lo out.
// Configuration: define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU (ops 6..9).
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        md_req,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

   md_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [63:0] pend_q, pend_d;     // result captured at acceptance
   logic        pdiv0_q, pdiv0_d;   // pending result must not be committed
`ifdef MDU_MADD_EN
   logic        acc_add_q, acc_add_d;
   logic        acc_sub_q, acc_sub_d;
`endif

   logic [63:0] prod;
   logic [31:0] quot;
   logic [31:0] rem;
   logic        div0;
   logic        mul_accept;
   logic [63:0] commit_val;

   mdu_arith u_arith (
      .a_i    (a),
      .b_i    (b),
      .op_i   (op),
      .prod_o (prod),
      .quot_o (quot),
      .rem_o  (rem),
      .div0_o (div0)
   );

`ifdef MDU_MADD_EN
   assign mul_accept = is_mul_op(op) || is_acc_op(op);
   // Accumulation uses HI/LO as they stand at the commit edge, not at acceptance.
   assign commit_val = acc_add_q ? ({hi_q, lo_q} + pend_q) :
                       acc_sub_q ? ({hi_q, lo_q} - pend_q) : pend_q;
`else
   assign mul_accept = is_mul_op(op);
   assign commit_val = pend_q;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      pend_d  = pend_q;
      pdiv0_d = pdiv0_q;
`ifdef MDU_MADD_EN
      acc_add_d = acc_add_q;
      acc_sub_d = acc_sub_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (mul_accept) begin
                  state_d = ST_MUL;
                  cnt_d   = CW'(MULT_CYCLES - 1);
                  pend_d  = prod;
                  pdiv0_d = 1'b0;
`ifdef MDU_MADD_EN
                  acc_add_d = (op == MD_MADD) || (op == MD_MADDU);
                  acc_sub_d = (op == MD_MSUB) || (op == MD_MSUBU);
`endif
               end else if (is_div_op(op)) begin
                  state_d = ST_DIV;
                  cnt_d   = CW'(DIV_CYCLES - 1);
                  pend_d  = {rem, quot};
                  pdiv0_d = div0;
`ifdef MDU_MADD_EN
                  acc_add_d = 1'b0;
                  acc_sub_d = 1'b0;
`endif
               end else if (op == MD_MTHI) begin
                  hi_d = a;
               end else if (op == MD_MTLO) begin
                  lo_d = a;
               end
               // remaining codes are ignored
            end
         end
         ST_MUL, ST_DIV: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               if (!pdiv0_q) begin
                  hi_d = commit_val[63:32];
                  lo_d = commit_val[31:0];
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         pend_q  <= '0;
         pdiv0_q <= 1'b0;
`ifdef MDU_MADD_EN
         acc_add_q <= 1'b0;
         acc_sub_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         pend_q  <= pend_d;
         pdiv0_q <= pdiv0_d;
`ifdef MDU_MADD_EN
         acc_add_q <= acc_add_d;
         acc_sub_q <= acc_sub_d;
`endif
      end
   end

   assign busy  = (state_q != ST_IDLE);
   // Combinational so a dependent mf* in D is held in the same cycle as start.
   assign stall = md_req & (busy | start);
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule
